// File: rtl/loopback_rx_pkt_counter.sv
// Frames the 64-bit loopback receive stream into packets, checks length and
// sequence number, and keeps the good-packet count plus saturating error counts.
module loopback_rx_pkt_counter #(
  parameter int unsigned PKT_WORDS = 16,
  parameter int unsigned WCNT_W    = 12,
  parameter int unsigned SEQ_LSB   = 0
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        rx_valid,
  input  logic [63:0] rx_data,
  input  logic        rx_eof,
  input  logic        rx_bad_frame,
  input  logic        cnt_rst,
  output logic [31:0] rx_cnt,
  output logic [31:0] rx_err,
  output logic        seq_lock,
  output logic        in_pkt
);

  localparam int unsigned SEQ_W = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ERR_W = 16;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PKT  = 1'b1;

  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [WCNT_W-1:0] PKT_LEN  = WCNT_W'(PKT_WORDS);

  logic [0:0]        state, state_nxt;
  logic [WCNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [SEQ_W-1:0]  cur_seq, cur_seq_nxt;
  logic [SEQ_W-1:0]  last_seq, last_seq_nxt;
  logic              seq_lock_nxt;
  logic [CNT_W-1:0]  rx_cnt_nxt;
  logic [ERR_W-1:0]  frame_err_cnt, frame_err_cnt_nxt;
  logic [ERR_W-1:0]  seq_err_cnt, seq_err_cnt_nxt;

  logic              eval;
  logic [WCNT_W-1:0] eval_len;
  logic [SEQ_W-1:0]  eval_seq;
  logic [SEQ_W-1:0]  beat_seq;
  logic [WCNT_W-1:0] word_cnt_inc;
  logic              unused_data;

  assign beat_seq     = rx_data[SEQ_LSB +: SEQ_W];
  assign unused_data  = ^rx_data;
  // Saturate so an oversize packet can never wrap back onto a legal length
  assign word_cnt_inc = (word_cnt == WCNT_MAX) ? WCNT_MAX : word_cnt + WCNT_W'(1);

  // Next-state and counter update
  always_comb begin
    state_nxt         = state;
    word_cnt_nxt      = word_cnt;
    cur_seq_nxt       = cur_seq;
    last_seq_nxt      = last_seq;
    seq_lock_nxt      = seq_lock;
    rx_cnt_nxt        = rx_cnt;
    frame_err_cnt_nxt = frame_err_cnt;
    seq_err_cnt_nxt   = seq_err_cnt;
    eval              = 1'b0;
    eval_len          = word_cnt_inc;
    eval_seq          = cur_seq;

    if (cnt_rst) begin
      state_nxt         = IDLE;
      word_cnt_nxt      = '0;
      cur_seq_nxt       = '0;
      last_seq_nxt      = '0;
      seq_lock_nxt      = 1'b0;
      rx_cnt_nxt        = '0;
      frame_err_cnt_nxt = '0;
      seq_err_cnt_nxt   = '0;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          cur_seq_nxt  = beat_seq;
          word_cnt_nxt = WCNT_W'(1);
          if (rx_eof) begin
            eval     = 1'b1;
            eval_len = WCNT_W'(1);
            eval_seq = beat_seq;
          end else begin
            state_nxt = PKT;
          end
        end
        default: begin
          word_cnt_nxt = word_cnt_inc;
          if (rx_eof) begin
            eval      = 1'b1;
            state_nxt = IDLE;
          end
        end
      endcase

      if (eval) begin
        if ((eval_len == PKT_LEN) && !rx_bad_frame) begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
          if (seq_lock && (eval_seq != last_seq + SEQ_W'(1)) && (seq_err_cnt != ERR_MAX)) begin
            seq_err_cnt_nxt = seq_err_cnt + ERR_W'(1);
          end
          last_seq_nxt = eval_seq;
          seq_lock_nxt = 1'b1;
        end else if (frame_err_cnt != ERR_MAX) begin
          frame_err_cnt_nxt = frame_err_cnt + ERR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state         <= IDLE;
      word_cnt      <= '0;
      cur_seq       <= '0;
      last_seq      <= '0;
      seq_lock      <= 1'b0;
      rx_cnt        <= '0;
      frame_err_cnt <= '0;
      seq_err_cnt   <= '0;
    end else begin
      state         <= state_nxt;
      word_cnt      <= word_cnt_nxt;
      cur_seq       <= cur_seq_nxt;
      last_seq      <= last_seq_nxt;
      seq_lock      <= seq_lock_nxt;
      rx_cnt        <= rx_cnt_nxt;
      frame_err_cnt <= frame_err_cnt_nxt;
      seq_err_cnt   <= seq_err_cnt_nxt;
    end
  end

  assign rx_err = {frame_err_cnt, seq_err_cnt};
  assign in_pkt = (state == PKT);

endmodule

// File: tb/tb_loopback_rx_pkt_counter.sv
// Randomised bench for loopback_rx_pkt_counter against a packet-level reference model.
module tb_loopback_rx_pkt_counter;

  localparam int PKT_WORDS = 16;
  localparam int WCNT_W    = 12;
  localparam int WMAX      = (1 << WCNT_W) - 1;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic        rx_eof;
  logic        rx_bad_frame;
  logic        cnt_rst;
  logic [31:0] rx_cnt;
  logic [31:0] rx_err;
  logic        seq_lock;
  logic        in_pkt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: packet-level view of the counters
  logic [31:0] m_cnt;
  logic [31:0] m_last;
  logic [31:0] m_seq;
  bit          m_lock;
  int          m_frame;
  int          m_seqerr;
  int          m_beats;

  loopback_rx_pkt_counter #(
    .PKT_WORDS(PKT_WORDS),
    .WCNT_W   (WCNT_W),
    .SEQ_LSB  (0)
  ) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_eof      (rx_eof),
    .rx_bad_frame(rx_bad_frame),
    .cnt_rst     (cnt_rst),
    .rx_cnt      (rx_cnt),
    .rx_err      (rx_err),
    .seq_lock    (seq_lock),
    .in_pkt      (in_pkt)
  );

  always #5 user_clk = ~user_clk;

  function automatic logic [31:0] exp_err();
    return {16'(m_frame), 16'(m_seqerr)};
  endfunction

  task automatic m_clear();
    m_cnt = '0; m_last = '0; m_seq = '0; m_lock = 1'b0;
    m_frame = 0; m_seqerr = 0; m_beats = 0;
  endtask

  // Drive one cycle of inputs, update the model, then move to #1 after the edge
  task automatic beat(input bit v, input logic [63:0] d, input bit e, input bit bf, input bit cr);
    int len;
    rx_valid = v; rx_data = d; rx_eof = e; rx_bad_frame = bf; cnt_rst = cr;
    if (cr) begin
      m_clear();
    end else if (v) begin
      if (m_beats == 0) m_seq = d[31:0];
      m_beats++;
      if (e) begin
        len = (m_beats > WMAX) ? WMAX : m_beats;
        if (len == PKT_WORDS && !bf) begin
          m_cnt = m_cnt + 32'd1;
          if (m_lock && m_seq != m_last + 32'd1 && m_seqerr < 65535) m_seqerr++;
          m_last = m_seq;
          m_lock = 1'b1;
        end else if (m_frame < 65535) begin
          m_frame++;
        end
        m_beats = 0;
      end
    end
    @(posedge user_clk);
    #1;
  endtask

  task automatic idle_beat();
    logic [63:0] d;
    d = {$urandom, $urandom};
    beat(1'b0, d, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send_pkt(input int len, input logic [31:0] seq, input bit bad, input int gap);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      d = (i == 0) ? {$urandom, seq} : {$urandom, $urandom};
      beat(1'b1, d, i == len - 1, (i == len - 1) ? bad : 1'($urandom), 1'b0);
      if (i < len - 1) for (int g = 0; g < gap; g++) idle_beat();
    end
  endtask

  task automatic clear_cnt();
    beat(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    cnt_rst = 1'b0;
  endtask

  task automatic test_reset();
    user_rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_eof = 1'b0;
    rx_bad_frame = 1'b0; cnt_rst = 1'b0;
    m_clear();
    repeat (2) @(posedge user_clk);
    #1;
    vectors++; if (rx_cnt !== 32'd0) begin miscompares++; $display("FAIL reset rx_cnt got %h exp 0", rx_cnt); end
    vectors++; if (rx_err !== 32'd0) begin miscompares++; $display("FAIL reset rx_err got %h exp 0", rx_err); end
    vectors++; if (seq_lock !== 1'b0) begin miscompares++; $display("FAIL reset seq_lock got %b exp 0", seq_lock); end
    vectors++; if (in_pkt !== 1'b0) begin miscompares++; $display("FAIL reset in_pkt got %b exp 0", in_pkt); end
    user_rst_n = 1'b1;
    @(posedge user_clk);
    #1;
  endtask

  task automatic test_good_seq();
    send_pkt(16, 32'd5, 1'b0, 0);
    send_pkt(16, 32'd6, 1'b0, 0);
    send_pkt(16, 32'd7, 1'b0, 0);
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL good_seq rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL good_seq rx_err got %h exp %h", rx_err, exp_err()); end
    vectors++; if (seq_lock !== m_lock) begin miscompares++; $display("FAIL good_seq seq_lock got %b exp %b", seq_lock, m_lock); end
    vectors++; if (in_pkt !== 1'b0) begin miscompares++; $display("FAIL good_seq in_pkt got %b exp 0", in_pkt); end
  endtask

  task automatic test_seq_err();
    clear_cnt();
    send_pkt(16, 32'd10, 1'b0, 0);
    send_pkt(16, 32'd11, 1'b0, 0);
    send_pkt(16, 32'd13, 1'b0, 0);
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL seq_err rx_err got %h exp %h", rx_err, exp_err()); end
    send_pkt(16, 32'd14, 1'b0, 1);
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL seq_err rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL seq_err last_seq rx_err got %h exp %h", rx_err, exp_err()); end
  endtask

  task automatic test_length();
    clear_cnt();
    send_pkt(15, 32'd1, 1'b0, 0);
    send_pkt(17, 32'd2, 1'b0, 0);
    send_pkt(16, 32'd3, 1'b1, 0);
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL length rx_err got %h exp %h", rx_err, exp_err()); end
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL length rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    vectors++; if (seq_lock !== m_lock) begin miscompares++; $display("FAIL length seq_lock got %b exp %b", seq_lock, m_lock); end
  endtask

  task automatic test_oversize();
    clear_cnt();
    send_pkt(4096 + PKT_WORDS, 32'd100, 1'b0, 0);
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL oversize rx_err got %h exp %h", rx_err, exp_err()); end
    send_pkt(16, 32'd101, 1'b0, 0);
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL oversize rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL oversize_next rx_err got %h exp %h", rx_err, exp_err()); end
  endtask

  task automatic test_wrap_gaps();
    clear_cnt();
    send_pkt(16, 32'hFFFF_FFFF, 1'b0, 3);
    vectors++; if (in_pkt !== 1'b0) begin miscompares++; $display("FAIL wrap in_pkt got %b exp 0", in_pkt); end
    send_pkt(16, 32'h0000_0000, 1'b0, 3);
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL wrap rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL wrap rx_err got %h exp %h", rx_err, exp_err()); end
  endtask

  task automatic test_cnt_rst_mid();
    logic [63:0] d;
    clear_cnt();
    for (int p = 1; p <= 4; p++) send_pkt(16, 32'(p), 1'b0, 0);
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL rst_mid pre rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      beat(1'b1, d, i == 15, 1'b0, i == 7);
      if (i == 7) begin
        vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL rst_mid rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
        vectors++; if (seq_lock !== m_lock) begin miscompares++; $display("FAIL rst_mid seq_lock got %b exp %b", seq_lock, m_lock); end
        vectors++; if (in_pkt !== 1'b0) begin miscompares++; $display("FAIL rst_mid in_pkt got %b exp 0", in_pkt); end
      end
    end
    cnt_rst = 1'b0;
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL rst_mid tail rx_err got %h exp %h", rx_err, exp_err()); end
    send_pkt(16, 32'd77, 1'b0, 0);
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL rst_mid after rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL rst_mid after rx_err got %h exp %h", rx_err, exp_err()); end
  endtask

  task automatic test_async_reset();
    logic [63:0] d;
    send_pkt(16, 32'd78, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      beat(1'b1, d, 1'b0, 1'b0, 1'b0);
    end
    rx_valid = 1'b0;
    user_rst_n = 1'b0;
    m_clear();
    #2;
    vectors++; if (rx_cnt !== 32'd0) begin miscompares++; $display("FAIL async rx_cnt got %0d exp 0", rx_cnt); end
    vectors++; if (in_pkt !== 1'b0) begin miscompares++; $display("FAIL async in_pkt got %b exp 0", in_pkt); end
    vectors++; if (seq_lock !== 1'b0) begin miscompares++; $display("FAIL async seq_lock got %b exp 0", seq_lock); end
    @(posedge user_clk);
    #1;
    user_rst_n = 1'b1;
    send_pkt(16, 32'd500, 1'b0, 0);
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL async after rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL async after rx_err got %h exp %h", rx_err, exp_err()); end
  endtask

  task automatic test_random();
    int lens[6] = '{1, 15, 16, 16, 16, 17};
    int len, gap;
    bit bad;
    logic [31:0] seq;
    logic [63:0] d;
    clear_cnt();
    for (int p = 0; p < 200; p++) begin
      len = lens[$urandom_range(0, 5)];
      bad = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 2);
      seq = ($urandom_range(0, 3) == 0) ? $urandom : m_last + 32'd1;
      for (int i = 0; i < len; i++) begin
        d = (i == 0) ? {$urandom, seq} : {$urandom, $urandom};
        beat(1'b1, d, i == len - 1, (i == len - 1) ? bad : 1'($urandom), 1'b0);
        vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL random p%0d b%0d rx_cnt got %0d exp %0d", p, i, rx_cnt, m_cnt); end
        vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL random p%0d b%0d rx_err got %h exp %h", p, i, rx_err, exp_err()); end
        vectors++; if (seq_lock !== m_lock) begin miscompares++; $display("FAIL random p%0d b%0d seq_lock got %b exp %b", p, i, seq_lock, m_lock); end
        vectors++; if (in_pkt !== (m_beats != 0)) begin miscompares++; $display("FAIL random p%0d b%0d in_pkt got %b exp %b", p, i, in_pkt, m_beats != 0); end
        if (i < len - 1) for (int g = 0; g < gap; g++) idle_beat();
      end
    end
  endtask

  task automatic test_err_sat();
    logic [63:0] d;
    clear_cnt();
    for (int n = 0; n < 65540; n++) begin
      d = {$urandom, $urandom};
      beat(1'b1, d, 1'b1, 1'($urandom), 1'b0);
    end
    vectors++; if (rx_err[31:16] !== 16'hFFFF) begin miscompares++; $display("FAIL err_sat frame_err_cnt got %h exp ffff", rx_err[31:16]); end
    vectors++; if (rx_err !== exp_err()) begin miscompares++; $display("FAIL err_sat rx_err got %h exp %h", rx_err, exp_err()); end
    vectors++; if (rx_cnt !== m_cnt) begin miscompares++; $display("FAIL err_sat rx_cnt got %0d exp %0d", rx_cnt, m_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_seq();
    test_seq_err();
    test_length();
    test_oversize();
    test_wrap_gaps();
    test_cnt_rst_mid();
    test_async_reset();
    test_random();
    test_err_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
